// File: rtl/ammrv_pipe_bridge_pkg.sv
// Shared types, default widths and helpers for the pipelined Avalon-MM retiming bridge.
package ammrv_pipe_bridge_pkg;

   localparam int unsigned AMM_ADDR_W = 32;
   localparam int unsigned AMM_DATA_W = 32;
   localparam int unsigned CMD_KIND_W = 2;

   typedef enum logic [CMD_KIND_W-1:0] {CMD_IDLE, CMD_RD, CMD_WR} amm_cmd_e;

   function automatic int unsigned be_w(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/ammrv_pipe_bridge_if.sv
// Avalon-MM pipelined bus (command, waitrequest, read response) with host/agent views.
interface ammrv_pipe_bridge_if #(
   parameter int unsigned ADDR_W = ammrv_pipe_bridge_pkg::AMM_ADDR_W,
   parameter int unsigned DATA_W = ammrv_pipe_bridge_pkg::AMM_DATA_W
);
   import ammrv_pipe_bridge_pkg::*;

   localparam int unsigned BE_W = be_w(DATA_W);

   logic [ADDR_W-1:0] address;
   logic [BE_W-1:0]   byteenable;
   logic [DATA_W-1:0] writedata;
   logic              read;
   logic              write;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, byteenable, writedata, read, write,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, writedata, read, write,
      output waitrequest, readdata, readdatavalid
   );

endinterface

// File: rtl/ammrv_pipe_bridge_skid_buf.sv
// Generic 2-entry skid buffer: main register drives the output, skid catches one command
// accepted while main is held. in_busy is registered so no ready path reaches the input.
module ammrv_pipe_bridge_skid_buf #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         areset,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_busy,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_pop
);

   logic         main_v, skid_v;
   logic         main_v_d, skid_v_d;
   logic [W-1:0] main_q, skid_q;
   logic         acc, main_free;

   assign acc       = in_valid & ~in_busy;
   assign main_free = ~main_v | out_pop;

   always_comb begin
      main_v_d = main_v;
      skid_v_d = skid_v;
      if (main_free) begin
         main_v_d = skid_v | acc;
         skid_v_d = 1'b0;
      end else if (acc) begin
         skid_v_d = 1'b1;
      end
   end

   // Busy resets high so nothing is accepted until the first clock after reset.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         main_v  <= 1'b0;
         skid_v  <= 1'b0;
         in_busy <= 1'b1;
      end else begin
         main_v  <= main_v_d;
         skid_v  <= skid_v_d;
         in_busy <= skid_v_d;
      end
   end

   always_ff @(posedge clk) begin
      if (main_free && (skid_v || acc)) main_q <= skid_v ? skid_q : in_data;
      if (!main_free && acc)            skid_q <= in_data;
   end

   assign out_valid = main_v;
   assign out_data  = main_q;

endmodule

// File: rtl/ammrv_pipe_bridge.sv
// Pipelined Avalon-MM retiming bridge: skid-buffered command path, read throttle on
// outstanding reads, sticky unexpected-response flag and optional response register.
module ammrv_pipe_bridge
   import ammrv_pipe_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W   = AMM_ADDR_W,
   parameter int unsigned DATA_W   = AMM_DATA_W,
   parameter int unsigned MAX_PEND = 4,
   parameter int unsigned RSP_FF   = 1
) (
   input  logic                            clk,
   input  logic                            areset,
   ammrv_pipe_bridge_if.slave              s,
   ammrv_pipe_bridge_if.master             m,
   output logic [$clog2(MAX_PEND+1)-1:0]   pend_cnt,
   output logic                            err_unexp_rdv
);

   localparam int unsigned BE_W   = be_w(DATA_W);
   localparam int unsigned PEND_W = $clog2(MAX_PEND+1);
   localparam int unsigned CMD_W  = CMD_KIND_W + ADDR_W + BE_W + DATA_W;
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

   amm_cmd_e          in_kind, main_kind;
   logic [CMD_W-1:0]  in_cmd, main_cmd;
   logic              main_v, issue, rd_issue;
   logic [PEND_W-1:0] pend_d;
   logic              err_d;

   // Read+write together is folded into a write.
   assign in_kind = s.write ? CMD_WR : CMD_RD;
   assign in_cmd  = {in_kind, s.address, s.byteenable, s.writedata};

   ammrv_pipe_bridge_skid_buf #(.W(CMD_W)) u_skid (
      .clk       (clk),
      .areset    (areset),
      .in_valid  (s.read | s.write),
      .in_data   (in_cmd),
      .in_busy   (s.waitrequest),
      .out_valid (main_v),
      .out_data  (main_cmd),
      .out_pop   (issue)
   );

   assign main_kind    = amm_cmd_e'(main_cmd[CMD_W-1 -: CMD_KIND_W]);
   assign m.address    = main_cmd[BE_W+DATA_W +: ADDR_W];
   assign m.byteenable = main_cmd[DATA_W +: BE_W];
   assign m.writedata  = main_cmd[0 +: DATA_W];

   // A throttled read blocks main, so later writes cannot overtake it.
   assign m.read   = main_v & (main_kind == CMD_RD) & (pend_cnt < PEND_MAX);
   assign m.write  = main_v & (main_kind == CMD_WR);
   assign issue    = (m.read | m.write) & ~m.waitrequest;
   assign rd_issue = issue & m.read;

   always_comb begin
      pend_d = pend_cnt;
      err_d  = err_unexp_rdv;
      case ({rd_issue, m.readdatavalid})
         2'b10:   pend_d = pend_cnt + PEND_W'(1);
         2'b01: begin
            if (pend_cnt == '0) err_d  = 1'b1;
            else                pend_d = pend_cnt - PEND_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         pend_cnt      <= '0;
         err_unexp_rdv <= 1'b0;
      end else begin
         pend_cnt      <= pend_d;
         err_unexp_rdv <= err_d;
      end
   end

   generate
      if (RSP_FF != 0) begin : g_rsp_ff
         logic              rdv_q;
         logic [DATA_W-1:0] rdata_q;

         always_ff @(posedge clk or posedge areset) begin
            if (areset) rdv_q <= 1'b0;
            else        rdv_q <= m.readdatavalid;
         end

         always_ff @(posedge clk) rdata_q <= m.readdata;

         assign s.readdatavalid = rdv_q;
         assign s.readdata      = rdata_q;
      end else begin : g_rsp_comb
         assign s.readdatavalid = m.readdatavalid;
         assign s.readdata      = m.readdata;
      end
   endgenerate

endmodule
